// File: rtl/axi4_ram_burst_if.sv
// AXI4 bus bundle for the burst RAM: write address/data/response and read address/data channels.
interface axi4_ram_burst_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_ram_burst.sv
// AXI4 slave RAM with independent write and read FSMs; FIXED/INCR/WRAP bursts,
// byte strobes, IDs and SLVERR on beats outside the RAM's byte space.
module axi4_ram_burst #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 1024
) (
  input logic             clk,
  input logic             reset_n,
  axi4_ram_burst_if.slave axi
);
  localparam int STRB_W   = DATA_W / 8;
  localparam int WORD_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int SPAN_LSB = WORD_LSB + IDX_W;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Reserved burst type falls through to INCR.
  function automatic logic [ADDR_W-1:0] f_next_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;
    bytes     = ADDR_W'(1) << size;
    incr      = (addr & ~(bytes - ADDR_W'(1))) + bytes;
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      BURST_FIXED: f_next_addr = addr;
      BURST_WRAP:  f_next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     f_next_addr = incr;
    endcase
  endfunction

  function automatic logic f_oor(input logic [ADDR_W-1:0] addr);
    f_oor = (addr >> SPAN_LSB) != '0;
  endfunction

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  // ---------------- write channel ----------------
  w_state_e          r_wr_state, w_wr_state_nxt;
  logic [ID_W-1:0]   r_aw_id;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [7:0]        r_aw_len;
  logic [2:0]        r_aw_size;
  logic [1:0]        r_aw_burst;
  logic [7:0]        r_wbeat;
  logic              r_werr;
  logic [ID_W-1:0]   r_bid;
  logic [1:0]        r_bresp;
  logic              w_awready, w_wready, w_bvalid;
  logic              w_aw_hs, w_w_hs, w_w_done, w_w_oor;
  logic [IDX_W-1:0]  w_w_idx;

  assign w_aw_hs  = axi.awvalid && w_awready;
  assign w_w_hs   = axi.wvalid && w_wready;
  assign w_w_done = w_w_hs && (axi.wlast || (r_wbeat == r_aw_len));
  assign w_w_oor  = f_oor(r_aw_addr);
  assign w_w_idx  = r_aw_addr[WORD_LSB +: IDX_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_wr_state <= W_IDLE;
    else          r_wr_state <= w_wr_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_awready      = 1'b0;
    w_wready       = 1'b0;
    w_bvalid       = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        w_awready = 1'b1;
        if (axi.awvalid) w_wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (w_w_done) w_wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (axi.bready) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_aw_id    <= '0;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_wbeat    <= '0;
      r_werr     <= 1'b0;
      r_bid      <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_id    <= axi.awid;
        r_aw_addr  <= axi.awaddr;
        r_aw_len   <= axi.awlen;
        r_aw_size  <= axi.awsize;
        r_aw_burst <= axi.awburst;
        r_wbeat    <= '0;
        r_werr     <= 1'b0;
      end
      if (w_w_hs) begin
        r_aw_addr <= f_next_addr(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
        r_wbeat   <= r_wbeat + 8'd1;
        if (w_w_oor) r_werr <= 1'b1;
        if (w_w_done) begin
          r_bid   <= r_aw_id;
          r_bresp <= (r_werr || w_w_oor) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents are undefined after power-up.
  always_ff @(posedge clk) begin
    if (w_w_hs && !w_w_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.wstrb[b]) r_mem[w_w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  assign axi.awready = w_awready;
  assign axi.wready  = w_wready;
  assign axi.bvalid  = w_bvalid;
  assign axi.bid     = r_bid;
  assign axi.bresp   = r_bresp;

  // ---------------- read channel ----------------
  r_state_e          r_rd_state, w_rd_state_nxt;
  logic [ADDR_W-1:0] r_ar_addr;
  logic [7:0]        r_ar_len;
  logic [2:0]        r_ar_size;
  logic [1:0]        r_ar_burst;
  logic [7:0]        r_rbeat;
  logic [ID_W-1:0]   r_rid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rlast;
  logic              w_arready, w_rvalid;
  logic              w_ar_hs, w_r_hs, w_rd_oor;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_ar_hs   = axi.arvalid && w_arready;
  assign w_r_hs    = w_rvalid && axi.rready;
  assign w_rd_addr = w_ar_hs ? axi.araddr
                             : f_next_addr(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
  assign w_rd_oor  = f_oor(w_rd_addr);
  assign w_rd_idx  = w_rd_addr[WORD_LSB +: IDX_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_state <= R_IDLE;
    else          r_rd_state <= w_rd_state_nxt;
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_arready      = 1'b0;
    w_rvalid       = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        w_arready = 1'b1;
        if (axi.arvalid) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (axi.rready && r_rlast) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // NOTE: non-blocking updates mean a beat fetched on the cycle its word is written returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_rbeat    <= '0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
    end else if (w_ar_hs) begin
      r_ar_addr  <= axi.araddr;
      r_ar_len   <= axi.arlen;
      r_ar_size  <= axi.arsize;
      r_ar_burst <= axi.arburst;
      r_rbeat    <= '0;
      r_rid      <= axi.arid;
      r_rlast    <= (axi.arlen == 8'd0);
      r_rdata    <= w_rd_oor ? '0 : r_mem[w_rd_idx];
      r_rresp    <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (w_r_hs) begin
      if (r_rlast) begin
        r_rlast <= 1'b0;
      end else begin
        r_ar_addr <= w_rd_addr;
        r_rbeat   <= r_rbeat + 8'd1;
        r_rlast   <= ((r_rbeat + 8'd1) == r_ar_len);
        r_rdata   <= w_rd_oor ? '0 : r_mem[w_rd_idx];
        r_rresp   <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign axi.arready = w_arready;
  assign axi.rvalid  = w_rvalid;
  assign axi.rid     = r_rid;
  assign axi.rdata   = r_rdata;
  assign axi.rresp   = r_rresp;
  assign axi.rlast   = r_rlast;

endmodule
